// File: rtl/guitar_pkg.sv
// guitar_pkg: shared types and screen constants for the falling-note scheduler.
//   note_slot_t   : one note object (active flag, lane, top-edge y).
//   sched_state_t : frame-scan FSM states.
//   LANE_X0 / LANE_PITCH : left edge of lane 0 and the spacing between lanes.
//   NOTE_W / NOTE_H      : note rectangle size in pixels.
package guitar_pkg;

    localparam int LANE_X0    = 200;
    localparam int LANE_PITCH = 60;
    localparam int NOTE_W     = 40;
    localparam int NOTE_H     = 10;

    typedef struct packed {
        logic       active;
        logic [1:0] lane;
        logic [9:0] ny;
    } note_slot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/note_rect_hit.sv
// note_rect_hit: combinational pixel coverage test for one note slot.
//   active, lane, ny : slot contents
//   x, y             : current pixel
//   covered          : pixel lies strictly inside the note rectangle
// Bounds are exclusive on every side, matching the fret-bar primitives.
module note_rect_hit
    import guitar_pkg::*;
(
    input  logic       active,
    input  logic [1:0] lane,
    input  logic [9:0] ny,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       covered
);

    // 11-bit arithmetic so ny+NOTE_H near the bottom of the screen cannot wrap.
    logic [10:0] lane_x;
    logic [10:0] x_w;
    logic [10:0] y_w;
    logic [10:0] ny_w;

    assign lane_x = 11'(LANE_X0) + 11'(lane) * 11'(LANE_PITCH);
    assign x_w    = {1'b0, x};
    assign y_w    = {1'b0, y};
    assign ny_w   = {1'b0, ny};

    assign covered = active
                   && (x_w > lane_x) && (x_w < lane_x + 11'(NOTE_W))
                   && (y_w > ny_w)   && (y_w < ny_w + 11'(NOTE_H));

endmodule

// File: rtl/guitar_note_sched.sv
// guitar_note_sched: note slot owner for the falling-note display.
//   clk, rst (sync, active-high)
//   frame_tick        : start-of-vblank pulse, launches one scan over all slots
//   spawn_valid/lane  : spawn request; spawn_ready when IDLE with a free slot
//   fret_btn          : fret levels, bit n = lane n
//   x, y / note_pixel : pixel coverage, one cycle latency
//   hit_pulse, miss_pulse, hit_count (saturating), frame_overrun
// Build option: NOTE_SCHED_HIT_EN enables fret hit detection; without it
// fret_btn is ignored, hit outputs stay 0 and notes only retire as misses.
module guitar_note_sched
    import guitar_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SPEED     = 4,
    parameter int BOTTOM_Y  = 480,
    parameter int HIT_TOP   = 400,
    parameter int HIT_BOT   = 440
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       spawn_valid,
    input  logic [1:0] spawn_lane,
    output logic       spawn_ready,
    input  logic [3:0] fret_btn,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       note_pixel,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] hit_count,
    output logic       frame_overrun
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    sched_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]     used_q, used_d;
    note_slot_t     slots_q [NUM_SLOTS];
    note_slot_t     slots_d [NUM_SLOTS];
    logic           hit_pulse_q, hit_pulse_d;
    logic           miss_pulse_q, miss_pulse_d;
    logic [7:0]     hit_count_q, hit_count_d;
    logic           overrun_q, overrun_d;
    logic           note_pixel_q, note_pixel_d;

    logic             any_free;
    logic [IDX_W-1:0] free_idx;
    note_slot_t       cur;
    logic [10:0]      sum;
    logic             in_window;
    logic             hit_now;
    logic [NUM_SLOTS-1:0] covered;

    // Lowest-index free slot: walk downward so the last hit wins.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots_q[i].active) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign spawn_ready = (state_q == ST_IDLE) && any_free;

    assign cur       = slots_q[idx_q];
    assign sum       = {1'b0, cur.ny} + 11'(SPEED);
    assign in_window = (cur.ny >= 10'(HIT_TOP)) && (cur.ny <= 10'(HIT_BOT));

`ifdef NOTE_SCHED_HIT_EN
    assign hit_now = cur.active && fret_btn[cur.lane] && !used_q[cur.lane] && in_window;
`else
    logic unused_hit_inputs;
    assign unused_hit_inputs = ^{fret_btn, in_window};
    assign hit_now = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        used_d       = used_q;
        slots_d      = slots_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        hit_count_d  = hit_count_q;
        overrun_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A spawn in the same cycle as frame_tick lands before the scan
                // reads any slot, so the new note advances in this frame.
                if (spawn_valid && spawn_ready) begin
                    slots_d[free_idx].active = 1'b1;
                    slots_d[free_idx].lane   = spawn_lane;
                    slots_d[free_idx].ny     = '0;
                end
                if (frame_tick) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    used_d  = '0;
                end
            end
            ST_SCAN: begin
                overrun_d = frame_tick;
                if (cur.active) begin
                    if (hit_now) begin
                        slots_d[idx_q]      = '0;
                        hit_pulse_d         = 1'b1;
                        used_d[cur.lane]    = 1'b1;
                        if (hit_count_q != 8'hFF) begin
                            hit_count_d = hit_count_q + 8'd1;
                        end
                    end else if (sum >= 11'(BOTTOM_Y)) begin
                        slots_d[idx_q] = '0;
                        miss_pulse_d   = 1'b1;
                    end else begin
                        slots_d[idx_q].ny = sum[9:0];
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                overrun_d = frame_tick;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_rect
            note_rect_hit u_rect (
                .active  (slots_q[gi].active),
                .lane    (slots_q[gi].lane),
                .ny      (slots_q[gi].ny),
                .x       (x),
                .y       (y),
                .covered (covered[gi])
            );
        end
    endgenerate

    assign note_pixel_d = |covered;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            used_q       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            hit_count_q  <= '0;
            overrun_q    <= 1'b0;
            note_pixel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            used_q       <= used_d;
            slots_q      <= slots_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hit_count_q  <= hit_count_d;
            overrun_q    <= overrun_d;
            note_pixel_q <= note_pixel_d;
        end
    end

    assign hit_pulse     = hit_pulse_q;
    assign miss_pulse    = miss_pulse_q;
    assign hit_count     = hit_count_q;
    assign frame_overrun = overrun_q;
    assign note_pixel    = note_pixel_q;

endmodule

// File: tb/tb_guitar_note_sched.sv
// tb_guitar_note_sched: directed bench for guitar_note_sched (8 slots, defaults).
// Expected values for hit behaviour follow NOTE_SCHED_HIT_EN when it is defined.
module tb_guitar_note_sched;

`ifdef NOTE_SCHED_HIT_EN
    localparam int HIT_EN = 1;
`else
    localparam int HIT_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       spawn_valid = 1'b0;
    logic [1:0] spawn_lane = 2'd0;
    logic       spawn_ready;
    logic [3:0] fret_btn = 4'd0;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       note_pixel;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [7:0] hit_count;
    logic       frame_overrun;

    int checks = 0;
    int errors = 0;

    guitar_note_sched dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .spawn_valid   (spawn_valid),
        .spawn_lane    (spawn_lane),
        .spawn_ready   (spawn_ready),
        .fret_btn      (fret_btn),
        .x             (x),
        .y             (y),
        .note_pixel    (note_pixel),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .hit_count     (hit_count),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       exp;
    } pix_vec_t;

    pix_vec_t pix_tab [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: got %0d", name, act);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One frame: pulse frame_tick, then watch long enough for the scan to
    // finish (NUM_SLOTS+2 cycles) and count result pulses.
    task automatic run_frame(output int h, output int m);
        h = 0;
        m = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (12) begin
            @(negedge clk);
            h += int'(hit_pulse);
            m += int'(miss_pulse);
        end
    endtask

    task automatic run_frames(input int n, output int h, output int m);
        int fh, fm;
        h = 0;
        m = 0;
        for (int i = 0; i < n; i++) begin
            run_frame(fh, fm);
            h += fh;
            m += fm;
        end
    endtask

    task automatic spawn(input logic [1:0] ln);
        int w;
        w = 0;
        @(negedge clk);
        while (!spawn_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL spawn_wait: spawn_ready still 0 after %0d cycles, expected 1", w);
        end
        spawn_valid = 1'b1;
        spawn_lane  = ln;
        @(negedge clk);
        spawn_valid = 1'b0;
    endtask

    task automatic probe(input logic [9:0] px, input logic [9:0] py, output logic p);
        @(negedge clk);
        x = px;
        y = py;
        @(negedge clk);
        p = note_pixel;
    endtask

    task automatic check_pix(input string name, input int px, input int py, input int exp);
        logic p;
        probe(10'(px), 10'(py), p);
        check($sformatf("%s pixel(%0d,%0d)", name, px, py), int'(p), exp);
    endtask

    initial begin
        int h, m, ov, hc;

        // Lane 1 note at ny=100: lane_x=260, covers 261..299 x 101..109.
        pix_tab[0] = '{px: 10'd261, py: 10'd105, exp: 1'b1};
        pix_tab[1] = '{px: 10'd260, py: 10'd105, exp: 1'b0};
        pix_tab[2] = '{px: 10'd261, py: 10'd110, exp: 1'b0};
        pix_tab[3] = '{px: 10'd299, py: 10'd109, exp: 1'b1};
        pix_tab[4] = '{px: 10'd300, py: 10'd105, exp: 1'b0};
        pix_tab[5] = '{px: 10'd261, py: 10'd100, exp: 1'b0};
        pix_tab[6] = '{px: 10'd321, py: 10'd105, exp: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset spawn_ready", int'(spawn_ready), 1);
        check("reset note_pixel", int'(note_pixel), 0);
        check("reset hit_pulse", int'(hit_pulse), 0);
        check("reset miss_pulse", int'(miss_pulse), 0);
        check("reset hit_count", int'(hit_count), 0);
        check("reset frame_overrun", int'(frame_overrun), 0);

        // Lane 2 note falls to the bottom: 119 frames -> ny=476, 120th misses.
        spawn(2'd2);
        run_frame(h, m);
        check_pix("A ny4", 321, 5, 1);
        check_pix("A ny4", 321, 4, 0);
        run_frames(118, h, m);
        check("A misses before bottom", m, 0);
        check_pix("A ny476", 321, 477, 1);
        check_pix("A ny476", 321, 476, 0);
        run_frame(h, m);
        check("A miss at sum=480", m, 1);
        check("A hit on miss frame", h, 0);
        check_pix("A freed", 321, 481, 0);
        check("A spawn_ready after miss", int'(spawn_ready), 1);

        // Pixel rectangle table: lane 1 note at ny=100.
        do_reset();
        spawn(2'd1);
        run_frames(25, h, m);
        for (int i = 0; i < 7; i++) begin
            logic p;
            probe(pix_tab[i].px, pix_tab[i].py, p);
            check($sformatf("F vec%0d pixel(%0d,%0d)", i, pix_tab[i].px, pix_tab[i].py),
                  int'(p), int'(pix_tab[i].exp));
        end

        // Two lane-1 notes in the hit window; one hit per lane per frame.
        do_reset();
        spawn(2'd1);
        run_frames(5, h, m);
        spawn(2'd1);
        run_frames(100, h, m);
        check("C no misses while falling", m, 0);
        fret_btn = 4'b1101;
        run_frame(h, m);
        check("C other lanes pressed hits", h, 0);
        fret_btn = 4'b0010;
        run_frame(h, m);
        check("C first press hits", h, HIT_EN);
        check("C first press misses", m, 0);
        check("C hit_count after 1", int'(hit_count), HIT_EN);
        check_pix("C slot1 ny408", 261, 409, 1);
        check_pix("C slot0 gone", 261, 429, 1 - HIT_EN);
        run_frame(h, m);
        check("C held press hits slot1", h, HIT_EN);
        check("C hit_count after 2", int'(hit_count), 2 * HIT_EN);
        check_pix("C slot1 gone", 261, 413, 1 - HIT_EN);
        fret_btn = 4'b0000;

        // Fill every slot; a held 9th request waits for a miss.
        do_reset();
        spawn(2'd3);
        run_frames(10, h, m);
        for (int i = 0; i < 7; i++) spawn(2'd3);
        @(negedge clk);
        check("D full spawn_ready", int'(spawn_ready), 0);
        spawn_valid = 1'b1;
        spawn_lane  = 2'd0;
        run_frames(109, h, m);
        check("D misses before first reaches bottom", m, 0);
        check("D still full", int'(spawn_ready), 0);
        check_pix("D 9th not taken", 201, 1, 0);
        run_frame(h, m);
        check("D one miss frees slot", m, 1);
        check("D 9th accepted, full again", int'(spawn_ready), 0);
        spawn_valid = 1'b0;
        check_pix("D 9th note at ny0", 201, 1, 1);

        // Second tick during SCAN: overrun pulse, no extra scan.
        ov = 0;
        m  = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ov += int'(frame_overrun);
            m  += int'(miss_pulse);
            if (c == 2) frame_tick = 1'b1;
            if (c == 3) frame_tick = 1'b0;
        end
        check("E frame_overrun pulses", ov, 1);
        check("E misses", m, 0);
        check_pix("E advanced once ny4", 201, 5, 1);
        check_pix("E lane3 at ny444", 381, 445, 1);

        // Reset while scanning: slots clear, FSM idle, no pulses.
        hc = 0;
        m  = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 4) begin
                hc += int'(hit_pulse);
                m  += int'(miss_pulse);
            end
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                check("R spawn_ready after rst", int'(spawn_ready), 1);
                rst = 1'b0;
            end
        end
        check("R no pulses after rst", hc + m, 0);
        check_pix("R lane3 cleared", 381, 445, 0);
        check_pix("R lane3 cleared", 381, 449, 0);
        check_pix("R lane0 cleared", 201, 9, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
